// File: rtl/wave_synth_if.sv
// TX sample bus between the waveform generator (master) and the DAC controller FIFO (slave).
interface wave_synth_if #(
  parameter int DATA_NBIT = 20
) ();
  logic                 tx_dv;
  logic [DATA_NBIT-1:0] tx_data;
  logic                 tx_waitrequest;

  modport master (output tx_dv, output tx_data, input tx_waitrequest);
  modport slave  (input tx_dv, input tx_data, output tx_waitrequest);
endinterface

// File: rtl/wave_synth.sv
// Phase-accumulator waveform generator (DC/square/saw/triangle) with offset and saturation.
// Define WAVE_AMP_SCALE_EN to add the amplitude multiplier stage (latency 3 instead of 2).
module wave_synth #(
  parameter int DATA_NBIT  = 20,
  parameter int PHASE_NBIT = 32
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst,
  input  logic                  enable,
  input  logic                  cfg_load,
  input  logic [1:0]            wave_sel,
  input  logic [PHASE_NBIT-1:0] freq_word,
  input  logic [16:0]           amp,
  input  logic [DATA_NBIT-1:0]  offset,
  output logic                  cfg_err,
  output logic [15:0]           sample_cnt,
  wave_synth_if.master          tx
);
`ifdef WAVE_AMP_SCALE_EN
  localparam int STAGES = 3;
`else
  localparam int STAGES = 2;
`endif
  localparam int N      = DATA_NBIT;
  localparam int SCL_W  = N + 2;
  localparam int PROD_W = N + 18;
  localparam int SUM_W  = N + 3;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2**(N-1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2**(N-1)));

  typedef enum logic [1:0] {W_DC = 2'b00, W_SQR = 2'b01, W_SAW = 2'b10, W_TRI = 2'b11} wave_e;

  logic [STAGES:1]         vld_q, vld_d;
  logic [PHASE_NBIT-1:0]   phase_q, phase_d, freq_q, freq_d;
  wave_e                   wave_q, wave_d;
  logic signed [N-1:0]     offset_q, offset_d, raw_q, raw_d, data_q, data_d;
  logic                    cfg_err_q, cfg_err_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    advance, empty, load_ok, issue;
  logic [N-1:0]            p, tri_u, raw_new, sat;
  logic signed [SUM_W-1:0] sum;
`ifdef WAVE_AMP_SCALE_EN
  logic [16:0]             amp_q, amp_d;
  logic signed [SCL_W-1:0] scaled_q, scaled_d;
`else
  logic unused_amp;
  assign unused_amp = ^amp;
`endif

  always_comb begin
    advance = ~(vld_q[STAGES] & tx.tx_waitrequest);
    empty   = ~|vld_q;
    load_ok = cfg_load & empty;
    issue   = enable & advance & ~load_ok;
    p       = phase_q[PHASE_NBIT-1 -: N];
    // triangle: doubled phase folded on the second half, then offset-binary to signed
    tri_u   = {p[N-2:0], 1'b0} ^ {N{p[N-1]}};
    case (wave_q)
      W_SQR:   raw_new = p[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
      W_SAW:   raw_new = {~p[N-1], p[N-2:0]};
      W_TRI:   raw_new = {~tri_u[N-1], tri_u[N-2:0]};
      default: raw_new = '0;
    endcase

`ifdef WAVE_AMP_SCALE_EN
    sum = SUM_W'(scaled_q) + SUM_W'(offset_q);
`else
    sum = SUM_W'(raw_q) + SUM_W'(offset_q);
`endif
    if (sum > SAT_MAX)      sat = SAT_MAX[N-1:0];
    else if (sum < SAT_MIN) sat = SAT_MIN[N-1:0];
    else                    sat = sum[N-1:0];

    phase_d  = phase_q;
    freq_d   = freq_q;
    wave_d   = wave_q;
    offset_d = offset_q;
    vld_d    = vld_q;
    raw_d    = raw_q;
    data_d   = data_q;
`ifdef WAVE_AMP_SCALE_EN
    amp_d    = amp_q;
    scaled_d = scaled_q;
`endif
    if (load_ok) begin
      phase_d  = '0;
      freq_d   = freq_word;
      wave_d   = wave_e'(wave_sel);
      offset_d = offset;
`ifdef WAVE_AMP_SCALE_EN
      amp_d    = amp;
`endif
    end else if (issue) begin
      phase_d = phase_q + freq_q;
    end

    // whole pipeline freezes while the output sample is held by back-pressure
    if (advance) begin
      vld_d = {vld_q[STAGES-1:1], issue};
      if (issue) raw_d = raw_new;
`ifdef WAVE_AMP_SCALE_EN
      if (vld_q[1]) scaled_d = SCL_W'((PROD_W'(raw_q) * PROD_W'($signed({1'b0, amp_q}))) >>> 16);
`endif
      if (vld_q[STAGES-1]) data_d = sat;
    end

    cfg_err_d = cfg_load & ~empty;
    cnt_d     = cnt_q + 16'(vld_q[STAGES] & ~tx.tx_waitrequest);
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      vld_q     <= '0;
      phase_q   <= '0;
      freq_q    <= '0;
      wave_q    <= W_DC;
      offset_q  <= '0;
      raw_q     <= '0;
      data_q    <= '0;
      cfg_err_q <= 1'b0;
      cnt_q     <= '0;
`ifdef WAVE_AMP_SCALE_EN
      amp_q     <= 17'h10000;
      scaled_q  <= '0;
`endif
    end else begin
      vld_q     <= vld_d;
      phase_q   <= phase_d;
      freq_q    <= freq_d;
      wave_q    <= wave_d;
      offset_q  <= offset_d;
      raw_q     <= raw_d;
      data_q    <= data_d;
      cfg_err_q <= cfg_err_d;
      cnt_q     <= cnt_d;
`ifdef WAVE_AMP_SCALE_EN
      amp_q     <= amp_d;
      scaled_q  <= scaled_d;
`endif
    end
  end

  assign tx.tx_dv    = vld_q[STAGES];
  assign tx.tx_data  = data_q;
  assign cfg_err     = cfg_err_q;
  assign sample_cnt  = cnt_q;
endmodule

// File: tb/tb_wave_synth.sv
// Scoreboard bench for wave_synth: expected samples queued at issue, checked in order on accept.
module tb_wave_synth;
  localparam int N = 20;
`ifdef WAVE_AMP_SCALE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0, rst = 1'b1, enable = 1'b0, cfg_load = 1'b0;
  logic [1:0]    wave_sel = '0;
  logic [31:0]   freq_word = '0;
  logic [16:0]   amp = 17'h10000;
  logic [N-1:0]  offset = '0;
  logic          cfg_err;
  logic [15:0]   sample_cnt;

  wave_synth_if #(.DATA_NBIT(N)) tx ();

  wave_synth #(.DATA_NBIT(N), .PHASE_NBIT(32)) dut (
    .tx_clk(clk), .tx_rst(rst), .enable(enable), .cfg_load(cfg_load),
    .wave_sel(wave_sel), .freq_word(freq_word), .amp(amp), .offset(offset),
    .cfg_err(cfg_err), .sample_cnt(sample_cnt), .tx(tx)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, acc_cnt = 0;
  logic [N-1:0] sb[$];
  logic [N-1:0] mon_exp;
  logic [1:0]   m_wave = '0;
  logic [31:0]  m_freq = '0, m_phase = '0;
  logic [16:0]  m_amp = 17'h10000;
  logic [N-1:0] m_off = '0;

  function automatic logic [N-1:0] model(input logic [31:0] ph);
    longint pp, raw, v;
    pp = longint'(ph >> 12);
    case (m_wave)
      2'b00:   raw = 0;
      2'b01:   raw = (pp >= 524288) ? -524288 : 524287;
      2'b10:   raw = pp - 524288;
      default: raw = ((pp < 524288) ? 2 * pp : 1048575 - 2 * (pp - 524288)) - 524288;
    endcase
`ifdef WAVE_AMP_SCALE_EN
    raw = (raw * longint'(m_amp)) >>> 16;
`endif
    v = raw + longint'($signed(m_off));
    if (v > 524287) v = 524287;
    if (v < -524288) v = -524288;
    return v[N-1:0];
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back(model(m_phase));
      m_phase = m_phase + m_freq;
    end
  endtask

  task automatic model_reset();
    sb.delete();
    acc_cnt = 0;
    m_wave = '0; m_freq = '0; m_amp = 17'h10000; m_off = '0; m_phase = '0;
  endtask

  task automatic load_cfg(input logic [1:0] w, input logic [31:0] f, input logic [16:0] a,
                          input logic [N-1:0] o);
    wave_sel = w; freq_word = f; amp = a; offset = o; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    m_wave = w; m_freq = f; m_amp = a; m_off = o; m_phase = '0;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while ((sb.size() != 0 || tx.tx_dv) && k < 200) begin tick(); k++; end
    n_vec++;
    if (k >= 200) begin n_err++; $display("FAIL %s_drain got_left=%0d exp_left=0", tag, sb.size()); end
  endtask

  task automatic stream(input int n, input string tag);
    push_n(n);
    enable = 1'b1;
    tick(n);
    enable = 1'b0;
    wait_drain(tag);
  endtask

  task automatic wait_dv(input string tag);
    int k = 0;
    while (!tx.tx_dv && k < 20) begin tick(); k++; end
    n_vec++;
    if (k >= 20) begin n_err++; $display("FAIL %s_wait_dv got=0 exp=1", tag); end
  endtask

  // accept monitor: sampled mid-cycle, so values match what the next edge will see
  always @(negedge clk) begin
    if (!rst && tx.tx_dv && !tx.tx_waitrequest) begin
      acc_cnt++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sample_unexpected got=%0d exp=none", $signed(tx.tx_data));
      end else begin
        mon_exp = sb.pop_front();
        if (tx.tx_data !== mon_exp) begin
          n_err++;
          $display("FAIL sample_%0d got=%0d exp=%0d", acc_cnt, $signed(tx.tx_data), $signed(mon_exp));
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_vec += 4;
    if (tx.tx_dv !== 1'b0)      begin n_err++; $display("FAIL rst_dv got=%b exp=0", tx.tx_dv); end
    if (tx.tx_data !== '0)      begin n_err++; $display("FAIL rst_data got=%0h exp=0", tx.tx_data); end
    if (cfg_err !== 1'b0)       begin n_err++; $display("FAIL rst_cfg_err got=%b exp=0", cfg_err); end
    if (sample_cnt !== 16'd0)   begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", sample_cnt); end
    rst = 1'b0;
    model_reset();
    stream(4, "dc_default");
    n_vec++;
    if (sample_cnt !== 16'd4) begin n_err++; $display("FAIL dc_default_cnt got=%0d exp=4", sample_cnt); end
  endtask

  task automatic test_square();
    load_cfg(2'b01, 32'h4000_0000, 17'h10000, '0);
    push_n(8);
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == LAT - 1) begin
        n_vec++;
        if (tx.tx_dv !== 1'b0) begin n_err++; $display("FAIL sq_lat_early got=%b exp=0", tx.tx_dv); end
      end
      if (k == LAT) begin
        n_vec++;
        if (tx.tx_dv !== 1'b1) begin n_err++; $display("FAIL sq_lat got=%b exp=1", tx.tx_dv); end
      end
    end
    enable = 1'b0;
    wait_drain("square");
  endtask

  task automatic test_saw();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    load_cfg(2'b10, 32'h1000_0000, 17'h10000, '0);
    stream(16, "saw");
    n_vec++;
    if (sample_cnt !== 16'd16) begin n_err++; $display("FAIL saw_cnt got=%0d exp=16", sample_cnt); end
    stream(2, "saw_wrap");
  endtask

  task automatic test_tri_dc();
    load_cfg(2'b11, 32'h0C80_0000, 17'h0C000, '0);
    stream(12, "triangle");
    load_cfg(2'b00, 32'h1234_5678, 17'h10000, N'(-77777));
    stream(3, "dc_offset");
  endtask

  task automatic test_sat();
    load_cfg(2'b01, 32'h4000_0000, 17'h18000, N'(100000));
    stream(8, "saturate");
  endtask

  task automatic test_stall();
    int k;
    load_cfg(2'b10, 32'h1000_0000, 17'h10000, N'(-5000));
    push_n(40);
    enable = 1'b1;
    wait_dv("stall");
    tick(2);
    tx.tx_waitrequest = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec += 3;
      if (tx.tx_dv !== 1'b1)          begin n_err++; $display("FAIL stall_dv_%0d got=%b exp=1", i, tx.tx_dv); end
      if (tx.tx_data !== sb[0])       begin n_err++; $display("FAIL stall_data_%0d got=%0d exp=%0d", i, $signed(tx.tx_data), $signed(sb[0])); end
      if (sample_cnt !== 16'(acc_cnt)) begin n_err++; $display("FAIL stall_cnt_%0d got=%0d exp=%0d", i, sample_cnt, acc_cnt); end
    end
    tx.tx_waitrequest = 1'b0;
    tick(4);
    enable = 1'b0;
    k = 0;
    while (tx.tx_dv && k < 20) begin tick(); k++; end
    n_vec += 2;
    if (k >= 20) begin n_err++; $display("FAIL stall_drain got_dv=1 exp_dv=0"); end
    if (sample_cnt !== 16'(acc_cnt)) begin n_err++; $display("FAIL stall_cnt_end got=%0d exp=%0d", sample_cnt, acc_cnt); end
    sb.delete();
  endtask

  task automatic test_cfg_reject();
    int k;
    load_cfg(2'b11, 32'h0300_0000, 17'h10000, '0);
    push_n(30);
    enable = 1'b1;
    wait_dv("reject");
    wave_sel = 2'b01; freq_word = 32'h4000_0000; offset = N'(12345); cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    n_vec++;
    if (cfg_err !== 1'b1) begin n_err++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
    tick();
    n_vec++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    tick(3);
    enable = 1'b0;
    k = 0;
    while (tx.tx_dv && k < 20) begin tick(); k++; end
    sb.delete();
    // load and enable together: the load wins, first new sample is from phase 0
    wave_sel = 2'b10; freq_word = 32'h0800_0000; amp = 17'h10000; offset = N'(777);
    cfg_load = 1'b1; enable = 1'b1;
    m_wave = 2'b10; m_freq = 32'h0800_0000; m_amp = 17'h10000; m_off = N'(777); m_phase = '0;
    push_n(6);
    tick();
    cfg_load = 1'b0;
    n_vec++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_accept_err got=%b exp=0", cfg_err); end
    tick(6);
    enable = 1'b0;
    wait_drain("cfg_accept");
  endtask

  task automatic test_reset_mid();
    load_cfg(2'b10, 32'h1000_0000, 17'h10000, N'(3000));
    push_n(30);
    enable = 1'b1;
    tick(LAT + 2);
    tx.tx_waitrequest = 1'b1;
    tick(3);
    rst = 1'b1; enable = 1'b0;
    sb.delete();
    tick();
    n_vec += 4;
    if (tx.tx_dv !== 1'b0)    begin n_err++; $display("FAIL mid_rst_dv got=%b exp=0", tx.tx_dv); end
    if (tx.tx_data !== '0)    begin n_err++; $display("FAIL mid_rst_data got=%0h exp=0", tx.tx_data); end
    if (cfg_err !== 1'b0)     begin n_err++; $display("FAIL mid_rst_cfg_err got=%b exp=0", cfg_err); end
    if (sample_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got=%0d exp=0", sample_cnt); end
    rst = 1'b0; tx.tx_waitrequest = 1'b0;
    model_reset();
    stream(4, "post_reset_cfg");
  endtask

  initial begin
    tx.tx_waitrequest = 1'b0;
    test_reset();
    test_square();
    test_saw();
    test_tri_dc();
    test_sat();
    test_stall();
    test_cfg_reject();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wave_synth.md
# wave_synth

Waveform sample generator feeding the AD5791 DAC controller's TX sample interface. Runs on `tx_clk` and produces signed 20-bit samples (DC, square, sawtooth, triangle) from a 32-bit phase accumulator, with optional amplitude scaling, offset and saturation. The DAC controller's internal FIFO sets the pace: this block keeps that FIFO full and honours `tx_waitrequest` back-pressure.

## Interface
- `DATA_NBIT`, 20, sample width; must equal the DAC data width.
- `PHASE_NBIT`, 32, phase accumulator width.
- `tx_clk`  in  1  block clock, same clock as the DAC controller's TX side.
- `tx_rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  while high, issue a new sample whenever the pipeline advances.
- `cfg_load`  in  1  one-cycle strobe; loads `wave_sel`/`freq_word`/`amp`/`offset` into active registers and clears phase.
- `wave_sel`  in  2  waveform select: 00 DC, 01 square, 10 sawtooth, 11 triangle.
- `freq_word`  in  PHASE_NBIT  phase increment per sample.
- `amp`  in  17  unsigned gain; 0x10000 = 1.0.
- `offset`  in  DATA_NBIT  signed offset added after scaling.
- `tx_dv`  out  1  sample valid.
- `tx_data`  out  DATA_NBIT  two's-complement sample.
- `tx_waitrequest`  in  1  DAC FIFO full; stalls the pipeline.
- `cfg_err`  out  1  one-cycle pulse: `cfg_load` rejected.
- `sample_cnt`  out  16  accepted-sample count; wraps.

## Operation
- Accept: `tx_dv & ~tx_waitrequest`.
- Advance: `~(tx_dv & tx_waitrequest)`. Every pipeline register moves only on advance.
- Issue: `enable & advance` inserts a sample at stage 1 computed from the current `phase`; then `phase <= phase + freq_word`, mod 2^PHASE_NBIT.
- Stage 1, raw sample. `p = phase[PHASE_NBIT-1 -: DATA_NBIT]`.
  - DC: 0.
  - Square: `+(2^(N-1)-1)` when `p` MSB = 0, else `-2^(N-1)`.
  - Sawtooth: `{~p[N-1], p[N-2:0]}`.
  - Triangle: `u = {p[N-2:0],1'b0}`, inverted bitwise when `p` MSB = 1; result is `u` with MSB flipped.
- Stage 2, scale (`WAVE_AMP_SCALE_EN` only): `(raw * amp) >>> 16`, full-width signed product, floor.
- Stage 3: add `offset` and saturate to `[-2^(N-1), 2^(N-1)-1]`. The output register drives `tx_data`/`tx_dv`.
- Draining: when `enable` goes low, in-flight samples still drain. `tx_dv` stays high with `tx_data` stable until the sample is accepted.
- `cfg_load` is honoured only when the pipeline is empty (no stage valid and `tx_dv` = 0). It loads all four config fields and sets `phase = 0`. Otherwise it is ignored and `cfg_err` pulses for 1 cycle.
- `cfg_load` and an issue in the same cycle: the load wins and the issue is suppressed. This case can only occur when the pipeline is empty.
- `sample_cnt` increments on each accept and wraps from 0xFFFF to 0.
- Reset (`tx_rst`, synchronous):
  - `tx_dv`, `tx_data`, `cfg_err`, `sample_cnt` = 0.
  - `phase` = 0 and all stage valids = 0.
  - Active config: `wave_sel` = 00, `freq_word` = 0, `amp` = 0x10000, `offset` = 0.
- Reset mid-stall discards all in-flight samples.

## Timing
- Latency from `enable` sampled high at cycle 0 with no stall: `tx_dv` = 1 at cycle 3 with `WAVE_AMP_SCALE_EN`, at cycle 2 without.
- Throughput: 1 sample per cycle while `tx_waitrequest` = 0.
- Stall: if `tx_waitrequest` = 1 while `tx_dv` = 1, no register changes (phase included) except `sample_cnt`/`cfg_err` housekeeping. The sample is accepted on the first cycle with `tx_waitrequest` = 0.
- `tx_waitrequest` while `tx_dv` = 0 has no effect; bubbles fill.
- `cfg_err` is asserted the cycle after the rejected `cfg_load`.

## Configuration
- `WAVE_AMP_SCALE_EN` defined: stage 2 multiplier present, `amp` honoured, latency 3.
- `WAVE_AMP_SCALE_EN` undefined: no multiplier, stage 2 removed, `amp` ignored (gain 1.0), latency 2. Offset add and saturation remain.

## Test plan
- Square, `freq_word` = 0x40000000, `amp` = 0x10000, `offset` = 0, no stall -> `tx_data` = 524287, 524287, -524288, -524288, repeating; `tx_dv` first high at cycle 3.
- Sawtooth, `freq_word` = 0x10000000 -> -524288, -458752, … , 458752, then wraps to -524288; `sample_cnt` = 16 after 16 accepts.
- Square, `amp` = 0x18000, `offset` = 100000 -> positive half saturates to 524287, negative half = -686432 clamped to -524288.
- `tx_waitrequest` held high 10 cycles with `tx_dv` = 1 -> `tx_data` stable, phase frozen; release -> samples resume with no skip or duplicate.
- `cfg_load` while `tx_dv` = 1 -> `cfg_err` pulses once and config is unchanged. Drop `enable`, wait for drain, then `cfg_load` -> accepted and first new sample uses phase 0.
- `tx_rst` asserted mid-stream -> next cycle all outputs 0 and config back to reset values.
